// File: rtl/gtfwizard_raw_gtwiz_buffbypass_tx_retry_if.sv
// rtl/gtfwizard_raw_gtwiz_buffbypass_tx_retry_if.sv - per-channel GT buffer-bypass signal bundle
interface gtfwizard_raw_gtwiz_buffbypass_tx_retry_if #(
  parameter int P_CHANNELS = 1
);
  // GT status towards the controller (asynchronous to the controller clock)
  logic [P_CHANNELS-1:0] txphaligndone_in;
  logic [P_CHANNELS-1:0] txsyncout_in;
  logic [P_CHANNELS-1:0] txsyncdone_in;
  // Controller drives towards the GT
  logic [P_CHANNELS-1:0] txdlysreset_out;
  logic [P_CHANNELS-1:0] txsyncmode_out;
  logic [P_CHANNELS-1:0] txsyncallin_out;
  logic [P_CHANNELS-1:0] txsyncin_out;
  logic [P_CHANNELS-1:0] txphdlypd_out;

  modport master (
    input  txphaligndone_in, txsyncout_in, txsyncdone_in,
    output txdlysreset_out, txsyncmode_out, txsyncallin_out, txsyncin_out, txphdlypd_out
  );

  modport slave (
    output txphaligndone_in, txsyncout_in, txsyncdone_in,
    input  txdlysreset_out, txsyncmode_out, txsyncallin_out, txsyncin_out, txphdlypd_out
  );
endinterface

// File: rtl/gtfwizard_raw_gtwiz_buffbypass_tx_retry.sv
// rtl/gtfwizard_raw_gtwiz_buffbypass_tx_retry.sv - TX buffer-bypass phase alignment controller with timeout and retry
module gtfwizard_raw_gtwiz_buffbypass_tx_retry #(
  parameter int P_TOTAL_NUMBER_OF_CHANNELS = 1,
  parameter int P_MASTER_CHANNEL_POINTER   = 0,
  parameter int P_SYNC_STAGES              = 4,
  parameter int P_RST_PULSE_CYCLES         = 2,
  parameter int P_TIMEOUT_CYCLES           = 65536,
  parameter int P_MAX_RETRIES              = 3
) (
  input  logic       gtwiz_buffbypass_tx_clk_in,
  input  logic       gtwiz_buffbypass_tx_reset_in,
  input  logic       gtwiz_buffbypass_tx_start_user_in,
  input  logic       gtwiz_buffbypass_tx_resetdone_in,
  input  logic       gtwiz_buffbypass_tx_phdlypd_in,
  output logic       gtwiz_buffbypass_tx_done_out,
  output logic       gtwiz_buffbypass_tx_error_out,
  output logic       gtwiz_buffbypass_tx_timeout_out,
  output logic       gtwiz_buffbypass_tx_busy_out,
  output logic [3:0] gtwiz_buffbypass_tx_retry_count_out,
  gtfwizard_raw_gtwiz_buffbypass_tx_retry_if.master gt
);

  localparam int N  = P_TOTAL_NUMBER_OF_CHANNELS;
  localparam int M  = P_MASTER_CHANNEL_POINTER;
  localparam int SW = N + 2;
  localparam int TW = $clog2(P_TIMEOUT_CYCLES);

  localparam logic [TW-1:0] TIMER_LAST = TW'(P_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    MAX_RETRY  = 4'(P_MAX_RETRIES);
  localparam logic [7:0]    PULSE_LOAD = 8'(P_RST_PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT,
    ST_EVAL,
    ST_DONE,
    ST_FAIL
  } state_t;

  logic clk;
  logic rst;
  assign clk = gtwiz_buffbypass_tx_clk_in;
  assign rst = gtwiz_buffbypass_tx_reset_in;

  // Synchronizer chain: {resetdone, master syncdone, phaligndone[N-1:0]}; powers up to 0, never reset
  logic [SW-1:0]                    sync_raw;
  logic [P_SYNC_STAGES-1:0][SW-1:0] sync_pipe = '0;
  logic [SW-1:0]                    sync_out;

  assign sync_raw = {gtwiz_buffbypass_tx_resetdone_in, gt.txsyncdone_in[M], gt.txphaligndone_in};

  // Shift every GT-sourced status bit through the same number of stages
  always_ff @(posedge clk) begin
    sync_pipe <= {sync_pipe[P_SYNC_STAGES-2:0], sync_raw};
  end

  assign sync_out = sync_pipe[P_SYNC_STAGES-1];

  logic [N-1:0] phalign_s;
  logic         syncdone_s;
  logic         resetdone_s;
  assign phalign_s   = sync_out[N-1:0];
  assign syncdone_s  = sync_out[N];
  assign resetdone_s = sync_out[N+1];

  state_t        state;
  logic          resetdone_q;
  logic          syncdone_q;
  logic          rd_armed;
  logic [7:0]    pulse_cnt;
  logic [TW-1:0] timer;
  logic          dlysreset;
  logic          done;
  logic          error;
  logic          timeout;
  logic [3:0]    retry_count;

  // rd_armed blocks a start from a resetdone that was already high when reset released
  logic rd_rise;
  logic rd_fall;
  logic sd_rise;
  logic retry_ok;
  logic all_aligned;
  assign rd_rise     = resetdone_s & ~resetdone_q & rd_armed;
  assign rd_fall     = ~resetdone_s & resetdone_q;
  assign sd_rise     = syncdone_s & ~syncdone_q;
  assign retry_ok    = retry_count < MAX_RETRY;
  assign all_aligned = &phalign_s;

  // Alignment sequencer: pulse TXDLYSRESET, wait for master sync done, verify all lanes, retry on failure
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dlysreset   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      timeout     <= 1'b0;
      retry_count <= '0;
      timer       <= '0;
      pulse_cnt   <= '0;
      resetdone_q <= 1'b0;
      syncdone_q  <= 1'b0;
      rd_armed    <= 1'b0;
    end else begin
      resetdone_q <= resetdone_s;
      syncdone_q  <= syncdone_s;
      if (!resetdone_s) begin
        rd_armed <= 1'b1;
      end

      if (state != ST_IDLE && rd_fall) begin
        // GT fell out of reset-done mid-procedure: drop everything but the diagnostics
        dlysreset <= 1'b0;
        done      <= 1'b0;
        error     <= 1'b0;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rd_rise || gtwiz_buffbypass_tx_start_user_in) begin
              done        <= 1'b0;
              error       <= 1'b0;
              timeout     <= 1'b0;
              retry_count <= '0;
              dlysreset   <= 1'b1;
              pulse_cnt   <= PULSE_LOAD;
              state       <= ST_PULSE;
            end
          end
          ST_PULSE: begin
            if (pulse_cnt == 8'd0) begin
              dlysreset <= 1'b0;
              timer     <= '0;
              state     <= ST_WAIT;
            end else begin
              pulse_cnt <= pulse_cnt - 8'd1;
            end
          end
          ST_WAIT: begin
            // A sync done edge takes priority over a timeout in the same clock
            if (sd_rise) begin
              state <= ST_EVAL;
            end else if (timer == TIMER_LAST) begin
              timeout <= 1'b1;
              if (retry_ok) begin
                retry_count <= retry_count + 4'd1;
                dlysreset   <= 1'b1;
                pulse_cnt   <= PULSE_LOAD;
                state       <= ST_PULSE;
              end else begin
                state <= ST_FAIL;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_EVAL: begin
            if (all_aligned) begin
              state <= ST_DONE;
            end else if (retry_ok) begin
              retry_count <= retry_count + 4'd1;
              dlysreset   <= 1'b1;
              pulse_cnt   <= PULSE_LOAD;
              state       <= ST_PULSE;
            end else begin
              state <= ST_FAIL;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            error <= 1'b0;
            state <= ST_IDLE;
          end
          ST_FAIL: begin
            done  <= 1'b1;
            error <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Master lane selects sync mode; all other lanes are slaves
  logic [N-1:0] mode_bits;
  always_comb begin
    mode_bits    = '0;
    mode_bits[M] = 1'b1;
  end

  assign gt.txdlysreset_out = {N{dlysreset}};
  assign gt.txsyncmode_out  = mode_bits;
  assign gt.txsyncallin_out = {N{&gt.txphaligndone_in}};
  assign gt.txsyncin_out    = {N{gt.txsyncout_in[M]}};
  assign gt.txphdlypd_out   = {N{gtwiz_buffbypass_tx_phdlypd_in}};

  assign gtwiz_buffbypass_tx_done_out        = done;
  assign gtwiz_buffbypass_tx_error_out       = error;
  assign gtwiz_buffbypass_tx_timeout_out     = timeout;
  assign gtwiz_buffbypass_tx_busy_out        = (state != ST_IDLE);
  assign gtwiz_buffbypass_tx_retry_count_out = retry_count;

endmodule

// File: tb/tb_gtfwizard_raw_gtwiz_buffbypass_tx_retry.sv
// tb/tb_gtfwizard_raw_gtwiz_buffbypass_tx_retry.sv - scoreboard bench for the TX buffer-bypass retry controller
module tb_gtfwizard_raw_gtwiz_buffbypass_tx_retry;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_user;
  logic       resetdone;
  logic       phdlypd;
  logic       done;
  logic       error;
  logic       timeout;
  logic       busy;
  logic [3:0] retry;

  gtfwizard_raw_gtwiz_buffbypass_tx_retry_if #(.P_CHANNELS(N)) gt_if ();

  gtfwizard_raw_gtwiz_buffbypass_tx_retry #(
    .P_TOTAL_NUMBER_OF_CHANNELS(N),
    .P_MASTER_CHANNEL_POINTER(2),
    .P_SYNC_STAGES(4),
    .P_RST_PULSE_CYCLES(2),
    .P_TIMEOUT_CYCLES(64),
    .P_MAX_RETRIES(2)
  ) dut (
    .gtwiz_buffbypass_tx_clk_in(clk),
    .gtwiz_buffbypass_tx_reset_in(rst),
    .gtwiz_buffbypass_tx_start_user_in(start_user),
    .gtwiz_buffbypass_tx_resetdone_in(resetdone),
    .gtwiz_buffbypass_tx_phdlypd_in(phdlypd),
    .gtwiz_buffbypass_tx_done_out(done),
    .gtwiz_buffbypass_tx_error_out(error),
    .gtwiz_buffbypass_tx_timeout_out(timeout),
    .gtwiz_buffbypass_tx_busy_out(busy),
    .gtwiz_buffbypass_tx_retry_count_out(retry),
    .gt(gt_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic       error;
    logic       timeout;
    logic [3:0] retry;
    logic [7:0] pulses;
    logic [7:0] high;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Monitor: tracks txdlysreset pulses per procedure and checks the scoreboard when busy falls
  logic prev_busy = 1'b0;
  logic prev_dly  = 1'b0;
  int   pulses = 0;
  int   high   = 0;
  int   split  = 0;
  int   pop_n  = 0;
  exp_t e;

  initial forever begin
    @(negedge clk);
    if (busy && !prev_busy) begin
      pulses = 0;
      high   = 0;
      split  = 0;
    end
    if (gt_if.txdlysreset_out != 4'b0000 && gt_if.txdlysreset_out != 4'b1111) split++;
    if (gt_if.txdlysreset_out[0]) begin
      high++;
      if (!prev_dly) pulses++;
    end
    if (!busy && prev_busy) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_end", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("r%0d_done", pop_n), int'(done), int'(e.done));
        chk($sformatf("r%0d_error", pop_n), int'(error), int'(e.error));
        chk($sformatf("r%0d_timeout", pop_n), int'(timeout), int'(e.timeout));
        chk($sformatf("r%0d_retry", pop_n), int'(retry), int'(e.retry));
        chk($sformatf("r%0d_pulses", pop_n), pulses, int'(e.pulses));
        chk($sformatf("r%0d_high", pop_n), high, int'(e.high));
        chk($sformatf("r%0d_split", pop_n), split, 0);
        pop_n++;
      end
    end
    prev_busy = busy;
    prev_dly  = gt_if.txdlysreset_out[0];
  end

  task automatic push(input logic d, input logic er, input logic t, input int r, input int p, input int h);
    exp_t x;
    x.done = d; x.error = er; x.timeout = t;
    x.retry = 4'(r); x.pulses = 8'(p); x.high = 8'(h);
    sb_q.push_back(x);
  endtask

  task automatic wait_dly(input logic v);
    int n = 0;
    while (gt_if.txdlysreset_out[0] !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("wait_dly_timeout", 0, 1);
  endtask

  task automatic wait_busy(input logic v);
    int n = 0;
    while (busy !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("wait_busy_timeout", 0, 1);
  endtask

  task automatic wait_retry(input int v);
    int n = 0;
    while (int'(retry) != v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("wait_retry_timeout", 0, 1);
  endtask

  task automatic kick();
    start_user = 1'b1;
    @(negedge clk);
    start_user = 1'b0;
  endtask

  task automatic check_idle_clear(input string tag);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_retry"}, int'(retry), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_dly"}, int'(gt_if.txdlysreset_out), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_user = 1'b0; resetdone = 1'b0; phdlypd = 1'b0;
    gt_if.txphaligndone_in = '0; gt_if.txsyncout_in = '0; gt_if.txsyncdone_in = '0;
    repeat (5) @(negedge clk);
    check_idle_clear("reset");

    // Static lane mappings
    chk("syncmode", int'(gt_if.txsyncmode_out), 4);
    gt_if.txphaligndone_in = 4'b1111; #1;
    chk("syncallin_all", int'(gt_if.txsyncallin_out), 15);
    gt_if.txphaligndone_in = 4'b1011; #1;
    chk("syncallin_part", int'(gt_if.txsyncallin_out), 0);
    gt_if.txsyncout_in = 4'b0100; #1;
    chk("syncin_hi", int'(gt_if.txsyncin_out), 15);
    gt_if.txsyncout_in = 4'b1011; #1;
    chk("syncin_lo", int'(gt_if.txsyncin_out), 0);
    phdlypd = 1'b1; #1;
    chk("phdlypd_hi", int'(gt_if.txphdlypd_out), 15);
    phdlypd = 1'b0; #1;
    chk("phdlypd_lo", int'(gt_if.txphdlypd_out), 0);
    gt_if.txsyncout_in = '0;
    gt_if.txphaligndone_in = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal: resetdone rising edge starts, syncdone 40 clocks into WAIT
    push(1, 0, 0, 0, 1, 2);
    resetdone = 1'b1;
    wait_dly(1'b1);
    wait_dly(1'b0);
    repeat (40) @(negedge clk);
    gt_if.txsyncdone_in[2] = 1'b1;
    wait_busy(1'b0);
    repeat (10) @(negedge clk);
    chk("done_hold", int'(done), 1);
    gt_if.txsyncdone_in[2] = 1'b0;
    repeat (8) @(negedge clk);

    // Two timeouts, syncdone on third attempt; start_user held in WAIT is ignored
    push(1, 0, 1, 2, 3, 6);
    kick();
    wait_retry(2);
    wait_dly(1'b0);
    start_user = 1'b1;
    repeat (10) @(negedge clk);
    start_user = 1'b0;
    repeat (3) @(negedge clk);
    gt_if.txsyncdone_in[2] = 1'b1;
    wait_busy(1'b0);
    gt_if.txsyncdone_in[2] = 1'b0;
    repeat (8) @(negedge clk);

    // Retries exhausted by timeouts
    push(1, 1, 1, 2, 3, 6);
    kick();
    wait_busy(1'b0);
    repeat (8) @(negedge clk);

    // Lane 1 never aligns: every attempt ends in EVAL failure
    gt_if.txphaligndone_in = 4'b1101;
    push(1, 1, 0, 2, 3, 6);
    kick();
    for (int a = 0; a < 3; a++) begin
      wait_dly(1'b1);
      gt_if.txsyncdone_in[2] = 1'b0;
      wait_dly(1'b0);
      repeat (6) @(negedge clk);
      gt_if.txsyncdone_in[2] = 1'b1;
    end
    wait_busy(1'b0);
    gt_if.txsyncdone_in[2] = 1'b0;
    gt_if.txphaligndone_in = 4'b1111;
    repeat (8) @(negedge clk);

    // Syncdone edge lands exactly on the last timer value
    push(1, 0, 0, 0, 1, 2);
    kick();
    wait_dly(1'b0);
    repeat (59) @(negedge clk);
    gt_if.txsyncdone_in[2] = 1'b1;
    wait_busy(1'b0);
    gt_if.txsyncdone_in[2] = 1'b0;
    repeat (8) @(negedge clk);

    // One clock later: the timeout wins, edge lost in PULSE, second attempt succeeds
    push(1, 0, 1, 1, 2, 4);
    kick();
    wait_dly(1'b0);
    repeat (60) @(negedge clk);
    gt_if.txsyncdone_in[2] = 1'b1;
    wait_dly(1'b1);
    gt_if.txsyncdone_in[2] = 1'b0;
    wait_dly(1'b0);
    repeat (6) @(negedge clk);
    gt_if.txsyncdone_in[2] = 1'b1;
    wait_busy(1'b0);
    gt_if.txsyncdone_in[2] = 1'b0;
    repeat (8) @(negedge clk);

    // resetdone drops during second attempt: abort keeps timeout and retry_count
    push(0, 0, 1, 1, 2, 4);
    kick();
    wait_retry(1);
    wait_dly(1'b0);
    repeat (10) @(negedge clk);
    resetdone = 1'b0;
    wait_busy(1'b0);
    repeat (8) @(negedge clk);

    // Fresh resetdone edge starts; reset during PULSE kills the pulse next clock
    push(0, 0, 0, 0, 1, 1);
    resetdone = 1'b1;
    wait_dly(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_dly_next", int'(gt_if.txdlysreset_out), 0);
    repeat (3) @(negedge clk);
    check_idle_clear("rst_mid");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_start_stale_rd", int'(busy), 0);
    chk("no_pulse_stale_rd", int'(gt_if.txdlysreset_out), 0);

    repeat (5) @(negedge clk);
    chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
